// File: rtl/up_counter_ctrl_pkg.sv
// Shared types and state encodings for the up_counter_ctrl sequencer.
package up_counter_ctrl_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    RUN   = ST_RUN,
    PAUSE = ST_PAUSE,
    DONE  = ST_DONE
  } ctrl_state_e;

endpackage

// File: rtl/up_counter_ctrl_counter.sv
// Modulo-N up-counter datapath: synchronous clear wins over enable, wraps at MOD_VALUE-1.
module mod_up_counter #(
  parameter  int MOD_VALUE = 8,
  localparam int CW        = $clog2(MOD_VALUE)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] count
);

  localparam logic [CW-1:0] LAST = CW'(MOD_VALUE - 1);

  logic [CW-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (clr)     count_d = '0;
    else if (en) count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/up_counter_ctrl.sv
// Start/pause/stop sequencer around mod_up_counter, one-shot or periodic.
// Optional step prescaler compiled in with UP_COUNTER_CTRL_PRESCALE_EN.
//
// state | meaning
// IDLE  | stopped, count held at 0
// RUN   | counting toward captured terminal count
// PAUSE | count frozen until pause drops
// DONE  | one-shot finished, count held at term_q
module up_counter_ctrl
  import up_counter_ctrl_pkg::*;
#(
  parameter  int MOD_VALUE = 8,
  parameter  int PRESCALE  = 4,
  localparam int CW        = $clog2(MOD_VALUE)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic          pause,
  input  logic          periodic,
  input  logic [CW-1:0] term,
  output logic [CW-1:0] count,
  output logic          tick,
  output logic          done,
  output logic          busy,
  output logic [1:0]    state
);

  localparam logic [CW-1:0] TERM_MAX = CW'(MOD_VALUE - 1);
  localparam logic [CW:0]   MOD_EXT  = (CW+1)'(MOD_VALUE);

  ctrl_state_e   state_d, state_q;
  logic [CW-1:0] term_d, term_q, term_sat, count_w;
  logic          periodic_d, periodic_q;
  logic          capture, step, tick_w, presc_hit, cnt_clr, cnt_en;

  // Only reachable for non power-of-two moduli.
  assign term_sat = ({1'b0, term} >= MOD_EXT) ? TERM_MAX : term;
  assign capture  = start & ~stop & ((state_q == IDLE) | (state_q == DONE));
  assign step     = (state_q == RUN) & ~pause & ~stop & presc_hit;
  assign tick_w   = step & (count_w == term_q);

`ifdef UP_COUNTER_CTRL_PRESCALE_EN
  localparam int              PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] presc_d, presc_q;

  assign presc_hit = (presc_q == PRESC_LAST);

  always_comb begin
    presc_d = presc_q;
    if (stop || capture || tick_w)        presc_d = '0;
    else if (state_q == RUN && !pause)    presc_d = presc_hit ? '0 : presc_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) presc_q <= '0;
    else     presc_q <= presc_d;
  end
`else
  assign presc_hit = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (stop) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (start) state_d = RUN;
        RUN: begin
          if (pause)                     state_d = PAUSE;
          else if (tick_w && !periodic_q) state_d = DONE;
        end
        PAUSE:   if (!pause) state_d = RUN;
        DONE:    if (start)  state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    done  = (state_q == DONE);
    busy  = (state_q == RUN) || (state_q == PAUSE);
    tick  = tick_w;
    state = state_q;
  end

  always_comb begin
    term_d     = term_q;
    periodic_d = periodic_q;
    if (capture) begin
      term_d     = term_sat;
      periodic_d = periodic;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      term_q     <= TERM_MAX;
      periodic_q <= 1'b0;
    end else begin
      term_q     <= term_d;
      periodic_q <= periodic_d;
    end
  end

  // One-shot terminal step must not increment: count holds term_q in DONE.
  assign cnt_clr = stop | capture | (tick_w & periodic_q);
  assign cnt_en  = step & ~tick_w;

  mod_up_counter #(.MOD_VALUE(MOD_VALUE)) u_counter (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .count (count_w)
  );

  assign count = count_w;

endmodule

// File: doc/up_counter_ctrl.md
# up_counter_ctrl

Sequencing controller for the MOD-N binary up counter. It starts, pauses, stops and restarts counting against a programmable terminal count, in one-shot or periodic mode, and flags completion. It sits between control logic (or a testbench) and the counter datapath, which it instantiates internally.

## Interface
- MOD_VALUE, 8: counter modulus; count range 0..MOD_VALUE-1.
- CW, $clog2(MOD_VALUE): count width (derived, not overridden).
- PRESCALE, 4: step divider; used only when the prescaler is compiled in (see Configuration).
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  start request; sampled each cycle.
- stop  in  1  abort; returns to IDLE.
- pause  in  1  level; holds count while high.
- periodic  in  1  1 = auto-reload at terminal count, 0 = one-shot; captured at start.
- term  in  CW  terminal count; captured at start.
- count  out  CW  current count.
- tick  out  1  terminal-count strobe.
- done  out  1  high in DONE.
- busy  out  1  high in RUN or PAUSE.
- state  out  2  current FSM state.

## Operation
- States: IDLE=0, RUN=1, PAUSE=2, DONE=3.
- Input priority: rst > stop > start > pause.
- IDLE: count=0. On start, capture term_q/periodic_q and go to RUN with count=0.
- term >= MOD_VALUE saturates to MOD_VALUE-1. This can only occur when MOD_VALUE is not a power of two.
- step = (state==RUN) & ~pause & ~stop. On each step, count increments.
- tick = step & (count==term_q). This is combinational from registered state/count plus the pause/stop inputs.
- On a tick step:
  - periodic_q=1: count goes to 0 and the FSM stays in RUN.
  - periodic_q=0: the FSM goes to DONE and count holds term_q.
- RUN with pause=1: no step that cycle; the FSM goes to PAUSE and count is held.
- PAUSE with pause=0: the FSM goes to RUN. start is ignored in PAUSE.
- start is ignored in RUN. There is no restart while busy.
- DONE: on start, recapture and go to RUN with count=0. Without start, stay in DONE.
- stop in any state: go to IDLE with count=0 on the next edge. Simultaneous start is ignored.
- term_q=0: tick on every step; count stays 0.
- Count never exceeds term_q. Increment is modulo MOD_VALUE, but wrap is never reached because term_q ≤ MOD_VALUE-1.

## Timing
- Reset values:
  - state=IDLE, count=0, done=0, busy=0, tick=0.
  - term_q=MOD_VALUE-1, periodic_q=0.
- rst asserted mid-operation returns all outputs to their reset values at the next edge.
- Start latency: start at edge k gives RUN with count=0 after edge k. The first increment (count=1) appears after edge k+1.
- One-shot with term=T: tick occurs in the (T+1)th RUN cycle; done goes high one cycle later.
- Periodic: tick period is T+1 cycles while unpaused.
- pause takes effect in the same cycle it is high, with no step that cycle. Resume costs one cycle: the PAUSE→RUN transition cycle.

## Configuration
- UP_COUNTER_CTRL_PRESCALE_EN defined:
  - A prescaler counting 0..PRESCALE-1 gates step. step additionally requires prescaler==PRESCALE-1.
  - The prescaler advances only in RUN while pause is low.
  - It clears on rst, start capture, stop and tick.
  - It holds in PAUSE.
- Undefined: step occurs on every unpaused RUN cycle, and PRESCALE is ignored.

## Structure
- Package up_counter_ctrl_pkg holds:
  - typedef enum logic [1:0] ctrl_state_e {IDLE, RUN, PAUSE, DONE};
  - state encoding constants.
- Sub-module mod_up_counter holds the counter datapath:
  - clk, rst, clr, en, count[CW-1:0].
  - Synchronous clear has priority over enable.
- FSM, capture registers and prescaler live in up_counter_ctrl.

## Test plan
- Reset: rst high for 2 cycles → state=0, count=0, busy=0, done=0, tick=0.
- One-shot: MOD_VALUE=8, term=5, periodic=0, single start pulse → count 0,1,2,3,4,5; one tick at count=5; then state=DONE, done=1, count held at 5.
- Periodic: term=2, periodic=1, start → count sequence 0,1,2,0,1,2; tick every 3rd cycle; busy stays 1.
- Pause: pause high for 3 cycles at count=3 → count holds 3, state=PAUSE, no tick; count=4 two cycles after pause drops.
- Boundaries:
  - stop and start asserted together during RUN → IDLE, count=0.
  - term=0 periodic → tick every cycle.
  - rst at count=4 → count=0, IDLE next cycle.
- Macro defined, PRESCALE=4, term=3, periodic=0 → count increments every 4th cycle; tick after 16 RUN cycles.
